mc_ctrl: RTL and testbench

Multicycle control unit for the MIPS-subset core. It replaces the single-cycle decoder with a Moore state machine that sequences one instruction across several clocks through a shared ALU and a single instruction/data memory port. It supports R-type, lw, sw, addi and beq, stalls on a memory-ready handshake, traps on unknown opcodes and counts retired instructions.

---
 rtl/mc_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle Moore control unit for the MIPS-subset core.
// It sequences one instruction over several clocks through a shared ALU and a
// single instruction/data memory port. Supported instructions are R-type, lw,
// sw, addi and beq. The unit stalls on mem_ready, traps on unknown opcodes and
// counts retired instructions.
module mc_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             irwrite,
  output logic             iord,
  output logic             regdst,
  output logic             regwrite,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [2:0]       aluop,
  output logic             pcsrc,
  output logic             er,
  output logic             ew,
  output logic             illegal,
  output logic             retired,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  state_t           state_reg;
  state_t           state_next;
  logic [5:0]       opc_reg;
  logic             run_reg;
  logic [CNT_W-1:0] cnt_reg;

  // run_reg is low during reset and for the partial cycle after release, so
  // the first real FETCH cycle starts on the first rising edge after rst_n
  // deasserts and every output stays forced low while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= 1'b1;
    end
  end

  // State register; held in FETCH until the unit is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
    end else if (run_reg) begin
      state_reg <= state_next;
    end
  end

  // Capture the opcode in DECODE so MEMADR can still tell lw from sw after the
  // instruction bits have moved on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_reg <= 6'd0;
    end else if (run_reg && (state_reg == S_DECODE)) begin
      opc_reg <= opcode;
    end
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (retired) begin
      cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state and Moore outputs (plus the mem_ready/zero qualified enables).
  always_comb begin
    state_next = state_reg;
    pcwrite    = 1'b0;
    irwrite    = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 3'b000;
    pcsrc      = 1'b0;
    er         = 1'b0;
    ew         = 1'b0;
    illegal    = 1'b0;
    retired    = 1'b0;
    if (run_reg) begin
      case (state_reg)
        S_FETCH: begin
          er      = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
          if (mem_ready) state_next = S_DECODE;
        end
        S_DECODE: begin
          // PC + (imm << 2) is formed here so BRANCH can use it from ALUOut.
          alusrcb = 2'b11;
          case (opcode)
            OP_RTYPE:     state_next = S_EXEC;
            OP_LW, OP_SW: state_next = S_MEMADR;
            OP_ADDI:      state_next = S_ADDIEX;
            OP_BEQ:       state_next = S_BRANCH;
            default:      state_next = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          state_next = (opc_reg == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          er   = 1'b1;
          iord = 1'b1;
          if (mem_ready) state_next = S_MEMWB;
        end
        S_MEMWB: begin
          regwrite   = 1'b1;
          memtoreg   = 1'b1;
          retired    = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMWR: begin
          ew   = 1'b1;
          iord = 1'b1;
          if (mem_ready) begin
            retired    = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_EXEC: begin
          alusrca    = 1'b1;
          aluop      = 3'b010;
          state_next = S_ALUWB;
        end
        S_ALUWB: begin
          regwrite   = 1'b1;
          regdst     = 1'b1;
          retired    = 1'b1;
          state_next = S_FETCH;
        end
        S_ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          state_next = S_ADDIWB;
        end
        S_ADDIWB: begin
          regwrite   = 1'b1;
          retired    = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          alusrca    = 1'b1;
          aluop      = 3'b001;
          pcsrc      = 1'b1;
          pcwrite    = zero;
          retired    = 1'b1;
          state_next = S_FETCH;
        end
        S_TRAP: begin
          illegal    = 1'b1;
          state_next = S_TRAP;
        end
        default: begin
          state_next = S_FETCH;
        end
      endcase
    end
  end

  assign retire_cnt = cnt_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for mc_ctrl. A default-width instance and a
// CNT_W=2 instance share all inputs; each cycle the current state and the
// packed control outputs are compared with hand-derived per-state vectors.
module tb_mc_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic        pcwrite, irwrite, iord, regdst, regwrite, memtoreg, alusrca;
  logic [1:0]  alusrcb;
  logic [2:0]  aluop;
  logic        pcsrc, er, ew, illegal, retired;
  logic [15:0] retire_cnt;
  logic [3:0]  state;

  logic        pcwrite2, irwrite2, iord2, regdst2, regwrite2, memtoreg2, alusrca2;
  logic [1:0]  alusrcb2;
  logic [2:0]  aluop2;
  logic        pcsrc2, er2, ew2, illegal2, retired2;
  logic [1:0]  retire_cnt2;
  logic [3:0]  state2;

  int tests_run = 0;
  int tests_failed = 0;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .irwrite(irwrite), .iord(iord), .regdst(regdst),
    .regwrite(regwrite), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .er(er), .ew(ew), .illegal(illegal),
    .retired(retired), .retire_cnt(retire_cnt), .state(state)
  );

  mc_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(pcwrite2), .irwrite(irwrite2), .iord(iord2), .regdst(regdst2),
    .regwrite(regwrite2), .memtoreg(memtoreg2), .alusrca(alusrca2), .alusrcb(alusrcb2),
    .aluop(aluop2), .pcsrc(pcsrc2), .er(er2), .ew(ew2), .illegal(illegal2),
    .retired(retired2), .retire_cnt(retire_cnt2), .state(state2)
  );

  // Packed order: pcwrite irwrite iord regdst regwrite memtoreg alusrca
  //               alusrcb[1:0] aluop[2:0] pcsrc er ew illegal retired
  logic [16:0] ctl;
  assign ctl = {pcwrite, irwrite, iord, regdst, regwrite, memtoreg, alusrca,
                alusrcb, aluop, pcsrc, er, ew, illegal, retired};

  localparam logic [16:0] C_ZERO    = 17'b0_0_0_0_0_0_0_00_000_0_0_0_0_0;
  localparam logic [16:0] C_FETCH1  = 17'b1_1_0_0_0_0_0_01_000_0_1_0_0_0;
  localparam logic [16:0] C_FETCH0  = 17'b0_0_0_0_0_0_0_01_000_0_1_0_0_0;
  localparam logic [16:0] C_DECODE  = 17'b0_0_0_0_0_0_0_11_000_0_0_0_0_0;
  localparam logic [16:0] C_MEMADR  = 17'b0_0_0_0_0_0_1_10_000_0_0_0_0_0;
  localparam logic [16:0] C_MEMRD   = 17'b0_0_1_0_0_0_0_00_000_0_1_0_0_0;
  localparam logic [16:0] C_MEMWB   = 17'b0_0_0_0_1_1_0_00_000_0_0_0_0_1;
  localparam logic [16:0] C_MEMWR0  = 17'b0_0_1_0_0_0_0_00_000_0_0_1_0_0;
  localparam logic [16:0] C_MEMWR1  = 17'b0_0_1_0_0_0_0_00_000_0_0_1_0_1;
  localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_1_00_010_0_0_0_0_0;
  localparam logic [16:0] C_ALUWB   = 17'b0_0_0_1_1_0_0_00_000_0_0_0_0_1;
  localparam logic [16:0] C_ADDIEX  = 17'b0_0_0_0_0_0_1_10_000_0_0_0_0_0;
  localparam logic [16:0] C_ADDIWB  = 17'b0_0_0_0_1_0_0_00_000_0_0_0_0_1;
  localparam logic [16:0] C_BRANCH1 = 17'b1_0_0_0_0_0_1_00_001_1_0_0_0_1;
  localparam logic [16:0] C_BRANCH0 = 17'b0_0_0_0_0_0_1_00_001_1_0_0_0_1;
  localparam logic [16:0] C_TRAP    = 17'b0_0_0_0_0_0_0_00_000_0_0_0_1_0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Check state and control vector for the current cycle, then advance.
  task automatic step(input string tag, input logic [3:0] es, input logic [16:0] ec);
    #1;
    chk({tag, ".state"}, {28'd0, state}, {28'd0, es});
    chk({tag, ".ctl"}, {15'd0, ctl}, {15'd0, ec});
    $display("[TB] %s state=%0d ctl=%b cnt=%0d", tag, state, ctl, retire_cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'd0;
    zero      = 1'b0;
    mem_ready = 1'b1;

    // Reset state: outputs forced low, counter cleared.
    repeat (2) @(posedge clk);
    #2;
    chk("rst.ctl", {15'd0, ctl}, 32'd0);
    chk("rst.state", {28'd0, state}, 32'd0);
    chk("rst.cnt", {16'd0, retire_cnt}, 32'd0);
    release_reset();

    // lw: 5 cycles; opcode changed after DECODE must not matter.
    opcode = 6'b100011;
    step("lw.fetch", 4'd0, C_FETCH1);
    step("lw.decode", 4'd1, C_DECODE);
    opcode = 6'b101011;
    step("lw.memadr", 4'd2, C_MEMADR);
    step("lw.memrd", 4'd3, C_MEMRD);
    step("lw.memwb", 4'd4, C_MEMWB);
    chk("lw.cnt", {16'd0, retire_cnt}, 32'd1);

    // sw with three stall cycles in MEMWR: 7 cycles, one retire.
    opcode = 6'b101011;
    step("sw.fetch", 4'd0, C_FETCH1);
    step("sw.decode", 4'd1, C_DECODE);
    step("sw.memadr", 4'd2, C_MEMADR);
    mem_ready = 1'b0;
    step("sw.memwr_s0", 4'd5, C_MEMWR0);
    step("sw.memwr_s1", 4'd5, C_MEMWR0);
    step("sw.memwr_s2", 4'd5, C_MEMWR0);
    mem_ready = 1'b1;
    step("sw.memwr_go", 4'd5, C_MEMWR1);
    chk("sw.cnt", {16'd0, retire_cnt}, 32'd2);

    // beq taken and not taken: 3 cycles each.
    opcode = 6'b000100;
    zero   = 1'b1;
    step("beq1.fetch", 4'd0, C_FETCH1);
    step("beq1.decode", 4'd1, C_DECODE);
    step("beq1.branch", 4'd8, C_BRANCH1);
    zero = 1'b0;
    step("beq0.fetch", 4'd0, C_FETCH1);
    step("beq0.decode", 4'd1, C_DECODE);
    step("beq0.branch", 4'd8, C_BRANCH0);
    chk("beq.cnt", {16'd0, retire_cnt}, 32'd4);

    // R-type then addi back-to-back: 8 cycles, two retires.
    opcode = 6'b000000;
    step("rt.fetch", 4'd0, C_FETCH1);
    step("rt.decode", 4'd1, C_DECODE);
    step("rt.exec", 4'd6, C_EXEC);
    step("rt.aluwb", 4'd7, C_ALUWB);
    opcode = 6'b001000;
    step("addi.fetch", 4'd0, C_FETCH1);
    step("addi.decode", 4'd1, C_DECODE);
    step("addi.addiex", 4'd9, C_ADDIEX);
    step("addi.addiwb", 4'd10, C_ADDIWB);
    chk("rtaddi.cnt", {16'd0, retire_cnt}, 32'd6);
    chk("rtaddi.cnt2", {30'd0, retire_cnt2}, 32'd2);

    // Reset, then five addi on the narrow counter: 1,2,3,0,1.
    rst_n = 1'b0;
    #1;
    chk("rst2.cnt2", {30'd0, retire_cnt2}, 32'd0);
    release_reset();
    opcode = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        mem_ready = 1'b0;
        step("addi5.fetch_stall", 4'd0, C_FETCH0);
        mem_ready = 1'b1;
      end
      step("addi5.fetch", 4'd0, C_FETCH1);
      step("addi5.decode", 4'd1, C_DECODE);
      step("addi5.addiex", 4'd9, C_ADDIEX);
      step("addi5.addiwb", 4'd10, C_ADDIWB);
      chk("addi5.cnt2", {30'd0, retire_cnt2}, (i == 3) ? 32'd0 : ((i == 4) ? 32'd1 : i + 1));
      chk("addi5.cnt", {16'd0, retire_cnt}, i + 1);
    end

    // Illegal opcode: TRAP at cycle 3, held with no enables.
    opcode = 6'b111111;
    step("trap.fetch", 4'd0, C_FETCH1);
    step("trap.decode", 4'd1, C_DECODE);
    opcode = 6'b000000;
    for (int i = 0; i < 21; i++) begin
      step("trap.hold", 4'd11, C_TRAP);
    end
    chk("trap.cnt", {16'd0, retire_cnt}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("trap.rst_state", {28'd0, state}, 32'd0);
    chk("trap.rst_ctl", {15'd0, ctl}, {15'd0, C_ZERO});
    chk("trap.rst_cnt", {16'd0, retire_cnt}, 32'd0);
    release_reset();

    // Reset asserted mid-MEMRD: er drops at once, counter clears.
    opcode = 6'b100011;
    step("rstrd.fetch", 4'd0, C_FETCH1);
    step("rstrd.decode", 4'd1, C_DECODE);
    step("rstrd.memadr", 4'd2, C_MEMADR);
    mem_ready = 1'b0;
    #1;
    chk("rstrd.er_before", {31'd0, er}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstrd.er_after", {31'd0, er}, 32'd0);
    chk("rstrd.cnt", {16'd0, retire_cnt}, 32'd0);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rstrd.held_ctl", {15'd0, ctl}, {15'd0, C_ZERO});
      chk("rstrd.held_state", {28'd0, state}, 32'd0);
    end
    release_reset();

    // Recovery: a fresh addi retires normally.
    opcode = 6'b001000;
    step("rec.fetch", 4'd0, C_FETCH1);
    step("rec.decode", 4'd1, C_DECODE);
    step("rec.addiex", 4'd9, C_ADDIEX);
    step("rec.addiwb", 4'd10, C_ADDIWB);
    chk("rec.cnt", {16'd0, retire_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
